// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, write-back select
// and an iterative M-extension unit. Define FAST_MUL_EN for a single-cycle multiplier.
module ex_stage_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func,
    input  logic            m_sel,
    input  logic [1:0]      alusrc,
    input  logic [3:0]      aluctrl,
    input  logic            flush,
    input  logic [XLEN-1:0] reg1_out,
    input  logic [XLEN-1:0] reg2_out,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_4,
    input  logic [1:0]      rs1_hzd,
    input  logic [1:0]      rs2_hzd,
    input  logic [XLEN-1:0] m_data_hzd,
    input  logic [XLEN-1:0] wb_data_hzd,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] mem_in,
    output logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] pc_in,
    output logic            pcsrc,
    output logic            stall,
    output logic            out_valid
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] ex_a, ex_b, alu_a, alu_b;
    logic [SHW-1:0]  shamt;
    logic            is_r, is_branch, is_jal, is_jalr, is_lui, taken;
    logic            issue, fast_issue, m_done, a_sgn_in, b_sgn_in;
    logic [XLEN-1:0] op_a, op_b, md, hi, lo, result, fix, fast_res;
    logic [XLEN-1:0] step_hi, step_lo, mul_neg_hi;
    logic [XLEN:0]   mul_sum, div_shift, div_trial;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      m_func;

    assign ex_a  = rs1_hzd[0] ? m_data_hzd : (rs1_hzd[1] ? wb_data_hzd : reg1_out);
    assign ex_b  = rs2_hzd[0] ? m_data_hzd : (rs2_hzd[1] ? wb_data_hzd : reg2_out);
    assign alu_a = alusrc[0] ? pc : ex_a;
    assign alu_b = alusrc[1] ? imm : ex_b;
    assign shamt = alu_b[SHW-1:0];

    always_comb begin
        case (aluctrl)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = alu_a & alu_b;
            4'd3:    alu_out = alu_a | alu_b;
            4'd4:    alu_out = alu_a ^ alu_b;
            4'd5:    alu_out = alu_a << shamt;
            4'd6:    alu_out = alu_a >> shamt;
            4'd7:    alu_out = $signed(alu_a) >>> shamt;
            4'd8:    alu_out = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'd9:    alu_out = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            default: alu_out = '0;
        endcase
    end

    assign is_r      = (opcode == OP_R);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);

    always_comb begin
        case (func)
            3'd0:    taken = (ex_a == ex_b);
            3'd1:    taken = (ex_a != ex_b);
            3'd4:    taken = ($signed(ex_a) < $signed(ex_b));
            3'd5:    taken = ($signed(ex_a) >= $signed(ex_b));
            3'd6:    taken = (ex_a < ex_b);
            3'd7:    taken = (ex_a >= ex_b);
            default: taken = 1'b0;
        endcase
    end

    assign pc_in     = is_jalr ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
    assign pcsrc     = valid_in & ~flush & ~stall & (is_jal | is_jalr | (is_branch & taken));
    assign mem_in    = ex_b;
    assign out_valid = m_done ? ~flush : (valid_in & ~flush & ~stall);

    always_comb begin
        if (is_lui)                data_in = imm;
        else if (is_jal | is_jalr) data_in = pc_4;
        else if (m_done)           data_in = result;
        else                       data_in = alu_out;
    end

    // Signed ops iterate on magnitudes; the sign is restored when the result is captured.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
        return (s && x[XLEN-1]) ? -x : x;
    endfunction

    assign issue    = (state == IDLE) & valid_in & ~flush & is_r & m_sel;
    assign a_sgn_in = (func == 3'd1) | (func == 3'd2) | (func == 3'd4) | (func == 3'd6);
    assign b_sgn_in = (func == 3'd1) | (func == 3'd4) | (func == 3'd6);

`ifdef FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_prod;
    assign fast_prod  = $signed({{XLEN{a_sgn_in & ex_a[XLEN-1]}}, ex_a}) *
                        $signed({{XLEN{b_sgn_in & ex_b[XLEN-1]}}, ex_b});
    assign fast_res   = (func == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    assign fast_issue = issue & ~func[2];
`else
    assign fast_res   = '0;
    assign fast_issue = 1'b0;
`endif

    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_trial = div_shift - {1'b0, md};

    always_comb begin
        if (m_func[2]) begin
            step_hi = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], ~div_trial[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // High half of the negated 2*XLEN product without a full-width negate.
    assign mul_neg_hi = ~step_hi + XLEN'(step_lo == '0);

    always_comb begin
        case (m_func)
            3'd0:    fix = step_lo;
            3'd1:    fix = (op_a[XLEN-1] ^ op_b[XLEN-1]) ? mul_neg_hi : step_hi;
            3'd2:    fix = op_a[XLEN-1] ? mul_neg_hi : step_hi;
            3'd4:    fix = (op_b == '0) ? '1 :
                           ((op_a[XLEN-1] ^ op_b[XLEN-1]) ? -step_lo : step_lo);
            3'd5:    fix = step_lo;
            3'd6:    fix = (op_b == '0) ? op_a : (op_a[XLEN-1] ? -step_hi : step_hi);
            default: fix = step_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = fast_issue ? DONE : BUSY;
            BUSY:    if (flush) state_next = IDLE;
                     else if (cnt == CNT_W'(XLEN-1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall  = 1'b0;
        m_done = 1'b0;
        case (state)
            IDLE:    stall  = issue;
            BUSY:    stall  = 1'b1;
            DONE:    m_done = 1'b1;
            default: stall  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            md     <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            m_func <= '0;
            result <= '0;
        end else if (issue) begin
            op_a   <= ex_a;
            op_b   <= ex_b;
            m_func <= func;
            cnt    <= '0;
            hi     <= '0;
            lo     <= func[2] ? mag(ex_a, a_sgn_in) : mag(ex_b, b_sgn_in);
            md     <= func[2] ? mag(ex_b, b_sgn_in) : mag(ex_a, a_sgn_in);
            if (fast_issue) result <= fast_res;
        end else if (state == BUSY) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) result <= fix;
        end
    end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboard bench for ex_stage_muldiv: directed vectors push expectations,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_ex_stage_muldiv;
    localparam int XLEN = 32;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam int DIV_STALL = 33;
`ifdef FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        pcsrc;
        logic [31:0] pc;
        logic        chk_pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n, valid_in, m_sel, flush, pcsrc, stall, out_valid;
    logic [6:0]      opcode;
    logic [2:0]      func;
    logic [1:0]      alusrc, rs1_hzd, rs2_hzd;
    logic [3:0]      aluctrl;
    logic [XLEN-1:0] reg1_out, reg2_out, imm, pc, pc_4, m_data_hzd, wb_data_hzd;
    logic [XLEN-1:0] alu_out, mem_in, data_in, pc_in;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    ex_stage_muldiv #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .func(func),
        .m_sel(m_sel), .alusrc(alusrc), .aluctrl(aluctrl), .flush(flush),
        .reg1_out(reg1_out), .reg2_out(reg2_out), .imm(imm), .pc(pc), .pc_4(pc_4),
        .rs1_hzd(rs1_hzd), .rs2_hzd(rs2_hzd), .m_data_hzd(m_data_hzd),
        .wb_data_hzd(wb_data_hzd), .alu_out(alu_out), .mem_in(mem_in),
        .data_in(data_in), .pc_in(pc_in), .pcsrc(pcsrc), .stall(stall),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one instruction, then hold it until stall drops (the DONE or 0-latency cycle).
    task automatic applyStimulus(input string name, input logic [6:0] op, input logic [2:0] fn,
                                 input logic msel, input logic [1:0] asrc, input logic [3:0] actrl,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] immv,
                                 input logic [31:0] pcv, input logic [31:0] pc4v,
                                 input logic [31:0] exp_data, input logic exp_pcsrc,
                                 input logic [31:0] exp_pc, input logic chk_pc, input int exp_stall);
        int stall_cycles;
        exp_q.push_back('{data: exp_data, pcsrc: exp_pcsrc, pc: exp_pc, chk_pc: chk_pc});
        name_q.push_back(name);
        @(posedge clk); #1;
        opcode = op; func = fn; m_sel = msel; alusrc = asrc; aluctrl = actrl;
        reg1_out = a; reg2_out = b; imm = immv; pc = pcv; pc_4 = pc4v;
        valid_in = 1'b1;
        stall_cycles = 0;
        @(negedge clk);
        while (stall && stall_cycles < 200) begin
            stall_cycles++;
            @(negedge clk);
        end
        checkOutput({name, "_stall_cycles"}, stall_cycles, exp_stall);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    exp_t  mon_e;
    string mon_n;
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                checkOutput({mon_n, "_data_in"}, data_in, mon_e.data);
                checkOutput({mon_n, "_pcsrc"}, {31'd0, pcsrc}, {31'd0, mon_e.pcsrc});
                if (mon_e.chk_pc) checkOutput({mon_n, "_pc_in"}, pc_in, mon_e.pc);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; m_sel = 1'b0;
        opcode = '0; func = '0; alusrc = '0; aluctrl = '0;
        reg1_out = '0; reg2_out = '0; imm = '0; pc = '0; pc_4 = '0;
        rs1_hzd = '0; rs2_hzd = '0; m_data_hzd = '0; wb_data_hzd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_pcsrc", {31'd0, pcsrc}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Forwarding: MEM path, WB path, MEM over WB priority.
        rs1_hzd = 2'b01; m_data_hzd = 32'd10;
        applyStimulus("add_fwd_mem", OP_R, 3'd0, 1'b0, 2'b00, 4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd4,
                      32'd17, 1'b0, 32'd0, 1'b0, 0);
        rs1_hzd = 2'b00; rs2_hzd = 2'b10; wb_data_hzd = 32'd5;
        applyStimulus("sub_fwd_wb", OP_R, 3'd0, 1'b0, 2'b00, 4'd1, 32'd3, 32'd99, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFE, 1'b0, 32'd0, 1'b0, 0);
        rs1_hzd = 2'b11; rs2_hzd = 2'b00; m_data_hzd = 32'h80000000; wb_data_hzd = 32'd1;
        applyStimulus("sra_fwd_prio", OP_I, 3'd5, 1'b0, 2'b10, 4'd7, 32'd0, 32'd0, 32'd4, 32'd0, 32'd4,
                      32'hF8000000, 1'b0, 32'd0, 1'b0, 0);
        rs1_hzd = 2'b00; m_data_hzd = '0; wb_data_hzd = '0;

        applyStimulus("slt", OP_R, 3'd2, 1'b0, 2'b00, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd4,
                      32'd1, 1'b0, 32'd0, 1'b0, 0);
        applyStimulus("sltu", OP_R, 3'd3, 1'b0, 2'b00, 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd4,
                      32'd0, 1'b0, 32'd0, 1'b0, 0);
        applyStimulus("sll_mask", OP_R, 3'd1, 1'b0, 2'b00, 4'd5, 32'd1, 32'h21, 32'd0, 32'd0, 32'd4,
                      32'd2, 1'b0, 32'd0, 1'b0, 0);
        applyStimulus("alu_unused", OP_R, 3'd0, 1'b0, 2'b00, 4'd12, 32'd9, 32'd9, 32'd0, 32'd0, 32'd4,
                      32'd0, 1'b0, 32'd0, 1'b0, 0);
        applyStimulus("lui", OP_LUI, 3'd0, 1'b0, 2'b10, 4'd0, 32'd0, 32'd0, 32'h12345000, 32'd0, 32'd4,
                      32'h12345000, 1'b0, 32'd0, 1'b0, 0);
        applyStimulus("auipc", OP_AUIPC, 3'd0, 1'b0, 2'b11, 4'd0, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'h1004,
                      32'h3000, 1'b0, 32'd0, 1'b0, 0);

        // Branches and jumps.
        applyStimulus("beq_taken", OP_BRANCH, 3'd0, 1'b0, 2'b11, 4'd0, 32'd4, 32'd4, 32'h20, 32'h100, 32'h104,
                      32'h120, 1'b1, 32'h120, 1'b1, 0);
        applyStimulus("bne_not", OP_BRANCH, 3'd1, 1'b0, 2'b11, 4'd0, 32'd4, 32'd4, 32'h20, 32'h100, 32'h104,
                      32'h120, 1'b0, 32'h120, 1'b1, 0);
        applyStimulus("blt_taken", OP_BRANCH, 3'd4, 1'b0, 2'b11, 4'd0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100,
                      32'h104, 32'h120, 1'b1, 32'h120, 1'b1, 0);
        applyStimulus("bltu_not", OP_BRANCH, 3'd6, 1'b0, 2'b11, 4'd0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100,
                      32'h104, 32'h120, 1'b0, 32'h120, 1'b1, 0);
        applyStimulus("jalr", OP_JALR, 3'd0, 1'b0, 2'b10, 4'd0, 32'h200, 32'd0, 32'd3, 32'h300, 32'h304,
                      32'h304, 1'b1, 32'h202, 1'b1, 0);
        applyStimulus("jal", OP_JAL, 3'd0, 1'b0, 2'b11, 4'd0, 32'd0, 32'd0, 32'h10, 32'h80, 32'h84,
                      32'h84, 1'b1, 32'h90, 1'b1, 0);

        // Multiply / divide.
        applyStimulus("mul", OP_R, 3'd0, 1'b1, 2'b00, 4'd0, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFD, 1'b0, 32'd0, 1'b0, MUL_STALL);
        applyStimulus("mulh", OP_R, 3'd1, 1'b1, 2'b00, 4'd0, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, MUL_STALL);
        applyStimulus("mulhsu", OP_R, 3'd2, 1'b1, 2'b00, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, MUL_STALL);
        applyStimulus("mulhu", OP_R, 3'd3, 1'b1, 2'b00, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFE, 1'b0, 32'd0, 1'b0, MUL_STALL);
        applyStimulus("div_ovf", OP_R, 3'd4, 1'b1, 2'b00, 4'd0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd4,
                      32'h80000000, 1'b0, 32'd0, 1'b0, DIV_STALL);
        applyStimulus("rem_ovf", OP_R, 3'd6, 1'b1, 2'b00, 4'd0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd4,
                      32'd0, 1'b0, 32'd0, 1'b0, DIV_STALL);
        applyStimulus("divu_zero", OP_R, 3'd5, 1'b1, 2'b00, 4'd0, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, DIV_STALL);
        applyStimulus("remu_zero", OP_R, 3'd7, 1'b1, 2'b00, 4'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd4,
                      32'd9, 1'b0, 32'd0, 1'b0, DIV_STALL);
        applyStimulus("div_neg", OP_R, 3'd4, 1'b1, 2'b00, 4'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFD, 1'b0, 32'd0, 1'b0, DIV_STALL);
        applyStimulus("rem_neg", OP_R, 3'd6, 1'b1, 2'b00, 4'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, DIV_STALL);
        applyStimulus("div_zero_s", OP_R, 3'd4, 1'b1, 2'b00, 4'd0, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, DIV_STALL);
        applyStimulus("rem_zero_s", OP_R, 3'd6, 1'b1, 2'b00, 4'd0, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, 32'd4,
                      32'hFFFFFFFB, 1'b0, 32'd0, 1'b0, DIV_STALL);

        // Flush a divu in its tenth busy cycle; no result may appear.
        @(posedge clk); #1;
        opcode = OP_R; func = 3'd5; m_sel = 1'b1; alusrc = 2'b00; aluctrl = 4'd0;
        reg1_out = 32'd100; reg2_out = 32'd7; valid_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_pcsrc", {31'd0, pcsrc}, 32'd0);
        checkOutput("flush_stall_held", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        checkOutput("flush_stall_released", {31'd0, stall}, 32'd0);
        applyStimulus("add_after_flush", OP_R, 3'd0, 1'b0, 2'b00, 4'd0, 32'd20, 32'd22, 32'd0, 32'd0, 32'd4,
                      32'd42, 1'b0, 32'd0, 1'b0, 0);

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        opcode = OP_R; func = 3'd5; m_sel = 1'b1;
        reg1_out = 32'd50; reg2_out = 32'd3; valid_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0; valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("busy_reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("busy_reset_pcsrc", {31'd0, pcsrc}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        applyStimulus("xor_after_reset", OP_R, 3'd4, 1'b0, 2'b00, 4'd4, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 32'd4,
                      32'h0FF0, 1'b0, 32'd0, 1'b0, 0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
- Parametrised execute stage for the RV32/RV64 pipeline.
- Performs operand forwarding, the ALU, branch/jump resolution and write-back data selection.
- Adds an iterative multiply/divide unit for the M extension. While a mul/div runs, the unit stalls the front of the pipeline.
- Sits between the ID/EX and EX/MEM pipeline registers. Its `stall` output freezes PC, IF/ID and ID/EX.

Parameters:
- XLEN, 32: datapath width. Legal values are 32 and 64.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  the ID/EX register holds a real instruction.
- opcode  in  7  instruction opcode.
- func  in  3  instruction funct3.
- m_sel  in  1  funct7 equals 0000001 (M-extension R-type).
- alusrc  in  2  bit0 selects A=pc; bit1 selects B=imm.
- aluctrl  in  4  ALU operation code.
- flush  in  1  kill the instruction in EX.
- reg1_out, reg2_out  in  XLEN  register file read data.
- imm  in  XLEN  sign-extended immediate.
- pc, pc_4  in  XLEN  instruction PC and PC+4.
- rs1_hzd, rs2_hzd  in  2  forwarding selects: bit0 takes the MEM value, bit1 takes the WB value.
- m_data_hzd, wb_data_hzd  in  XLEN  forwarded data.
- alu_out  out  XLEN  ALU result / memory address.
- mem_in  out  XLEN  store data.
- data_in  out  XLEN  write-back data.
- pc_in  out  XLEN  branch/jump target.
- pcsrc  out  1  redirect the PC to pc_in.
- stall  out  1  hold upstream stages and do not advance EX/MEM.
- out_valid  out  1  the EX result is valid this cycle.

Behaviour:
- Forwarding: ex_A = rs1_hzd[0] ? m_data_hzd : rs1_hzd[1] ? wb_data_hzd : reg1_out. ex_B is formed the same way. MEM has priority over WB.
- ALU inputs: A = alusrc[0] ? pc : ex_A; B = alusrc[1] ? imm : ex_B.
- aluctrl encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu. Codes 10-15 give 0.
  - Shift amount is B[log2(XLEN)-1:0].
  - slt/sltu return a zero-extended 1-bit result.
- Opcodes: R 0110011, I 0010011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
- Branch condition on ex_A/ex_B by func: 0 eq, 1 ne, 4 lt, 5 ge, 6 ltu, 7 geu. func 2 and 3 never take.
- pc_in:
  - alu_out for jal and branch.
  - alu_out with bit0 cleared for jalr.
- pcsrc = valid_in & ~flush & ~stall & (jal | jalr | taken branch).
- mem_in = ex_B.
- data_in selection:
  - lui gives imm.
  - jal/jalr give pc_4.
  - mul/div in DONE gives the result register.
  - Otherwise alu_out.
- Non-M instructions are combinational (latency 0): out_valid = valid_in & ~flush & ~stall.
- M-unit state machine: IDLE, BUSY, DONE.
  - Issue condition: IDLE & valid_in & ~flush & opcode==R & m_sel. In the issue cycle:
    - stall=1 combinationally;
    - ex_A/ex_B are latched;
    - the counter is loaded with 0;
    - the next state is BUSY.
  - BUSY:
    - stall=1.
    - mul* runs one shift-add step per cycle; div*/rem* runs one restoring step per cycle.
    - After XLEN steps the next state is DONE.
  - DONE:
    - stall=0, out_valid=1, data_in = result.
    - The next state is always IDLE. The held instruction is not re-issued.
  - Total occupancy: XLEN+2 cycles, including the issue cycle.
- M results by func:
  - 0 mul: low XLEN bits.
  - 1 mulh: signed×signed, high XLEN bits.
  - 2 mulhsu: signed×unsigned, high XLEN bits.
  - 3 mulhu: unsigned×unsigned, high XLEN bits.
  - 4 div, 5 divu, 6 rem, 7 remu.
  - Signed ops run on magnitudes with a sign fix-up applied at DONE entry.
- Divide by zero: quotient is all ones; remainder is the dividend.
- Signed overflow (MIN / -1): quotient is MIN; remainder is 0.
- flush while in BUSY or DONE:
  - the state returns to IDLE on the next edge;
  - out_valid=0 and pcsrc=0 in the flush cycle;
  - stall deasserts the cycle after.
- Reset: state IDLE, counter 0, result and operand registers 0, stall 0, out_valid 0, pcsrc 0.
- Upstream must hold all EX inputs stable while stall=1. Forwarded values are sampled only at issue.

Optional Feature:
- Macro: FAST_MUL_EN.
- Defined:
  - mul/mulh/mulhsu/mulhu use a single-cycle 2·XLEN product.
  - The issue cycle goes straight to DONE, giving 2-cycle occupancy.
  - Division is unchanged.
- Undefined: multiplies are iterative with XLEN+2 occupancy, and no 2·XLEN-wide multiplier is synthesised.

Test Plan:
- add, reg1=5, reg2=7, rs1_hzd=01, m_data_hzd=10, aluctrl=0 -> data_in=17, out_valid=1, stall=0.
- mul, XLEN=32, A=0xFFFFFFFF (-1), B=3, func=0 then func=1 -> stall held for 33 cycles; DONE data_in=0xFFFFFFFD, then 0xFFFFFFFF.
- div, A=0x80000000, B=0xFFFFFFFF -> 0x80000000. rem on the same operands -> 0. divu with B=0 -> 0xFFFFFFFF. remu 9/0 -> 9.
- beq, equal operands, pc=0x100, imm=0x20, alusrc=11 -> pcsrc=1, pc_in=0x120. jalr with target 0x203 -> pc_in=0x202, data_in=pc_4.
- Issue divu, assert flush in BUSY cycle 10 -> no out_valid; IDLE next edge; next add completes with 0 latency.
- rst_n=0 during BUSY -> next edge: stall=0, out_valid=0, state IDLE. With FAST_MUL_EN: mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE in 2 cycles.
